// File: rtl/tbman_regs.sv
// Testbench-manager register block: console FIFO, pass/fail result FSM with watchdog,
// 64-bit cycle counter with coherent high-word snapshot, and a scratch word.
module tbman_regs #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned WDT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        CS_TBMAN_N,
  input  logic        WE,
  input  logic [3:0]  BE,
  input  logic [11:0] Addr,
  input  logic [31:0] WData,
  output logic [31:0] RData,
  output logic [7:0]  char_data,
  output logic        char_valid,
  input  logic        char_ready,
  output logic        test_done,
  output logic        test_pass,
  output logic        test_timeout
);

  localparam int unsigned PW        = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_CNT = FIFO_DEPTH[PW:0];
  localparam logic        WDT_EN    = (WDT_CYCLES != 32'd0);
  localparam logic [31:0] WDT_LAST  = WDT_CYCLES - 32'd1;

  localparam logic [9:0] OFS_PRINT   = 10'h000;
  localparam logic [9:0] OFS_STATUS  = 10'h001;
  localparam logic [9:0] OFS_CYC_LO  = 10'h002;
  localparam logic [9:0] OFS_CYC_HI  = 10'h003;
  localparam logic [9:0] OFS_FSTAT   = 10'h004;
  localparam logic [9:0] OFS_SCRATCH = 10'h005;

  localparam logic [31:0] CODE_PASS = 32'h0000_600D;
  localparam logic [31:0] CODE_FAIL = 32'h0000_0BAD;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PASSED  = 2'd1,
    ST_FAILED  = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_t;

  function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = new_v[8*b +: 8];
    end
    return res;
  endfunction

  logic [63:0]   cyc_r;
  logic [31:0]   hi_snap_r;
  logic [31:0]   rdata_r;
  logic [31:0]   scratch_r;
  logic [31:0]   wdt_r;
  logic [7:0]    mem_r [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [PW:0]   count_r;
  logic          overflow_r;
  state_t        state_r;
  logic          done_r;
  logic          pass_r;
  logic          timeout_r;

  logic          acc_s;
  logic          wr_s;
  logic          rd_s;
  logic [9:0]    ofs_s;
  logic          full_s;
  logic          valid_s;
  logic          pop_s;
  logic          push_req_s;
  logic          push_s;
  logic          status_acc_s;
  logic          status_wr_s;
  logic          fstat_clr_s;
  logic [31:0]   rd_val_s;
  logic          unused_addr_s;

  assign unused_addr_s = &{1'b0, Addr[1:0]};

  // Access decode, FIFO handshake and read-data mux
  always_comb begin
    acc_s        = ~CS_TBMAN_N;
    wr_s         = acc_s & WE;
    rd_s         = acc_s & ~WE;
    ofs_s        = Addr[11:2];
    full_s       = (count_r == DEPTH_CNT);
    valid_s      = (count_r != {(PW+1){1'b0}});
    pop_s        = valid_s & char_ready;
    push_req_s   = wr_s & (ofs_s == OFS_PRINT) & BE[0];
    // A full FIFO still takes the push when the head leaves in the same cycle
    push_s       = push_req_s & (~full_s | pop_s);
    status_acc_s = acc_s & (ofs_s == OFS_STATUS);
    status_wr_s  = wr_s & (ofs_s == OFS_STATUS) & (BE == 4'hF);
    fstat_clr_s  = wr_s & (ofs_s == OFS_FSTAT) & BE[3];
    rd_val_s     = 32'h0000_0000;
    case (ofs_s)
      OFS_STATUS:  rd_val_s = {29'd0, timeout_r, pass_r, done_r};
      OFS_CYC_LO:  rd_val_s = cyc_r[31:0];
      OFS_CYC_HI:  rd_val_s = hi_snap_r;
      OFS_FSTAT:   rd_val_s = {overflow_r, 15'd0, full_s, {(15-PW-1){1'b0}}, count_r};
      OFS_SCRATCH: rd_val_s = scratch_r;
      default:     rd_val_s = 32'h0000_0000;
    endcase
  end

  // Free-running cycle counter, coherent high-word snapshot and registered read port
  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_r     <= 64'd0;
      hi_snap_r <= 32'd0;
      rdata_r   <= 32'd0;
    end else begin
      cyc_r <= cyc_r + 64'd1;
      if (rd_s) rdata_r <= rd_val_s;
      if (rd_s && (ofs_s == OFS_CYC_LO)) hi_snap_r <= cyc_r[63:32];
    end
  end

  // Console FIFO storage (no reset needed: reads are gated by the occupancy count)
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r] <= WData[7:0];
  end

  // Console FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r   <= {PW{1'b0}};
      rd_ptr_r   <= {PW{1'b0}};
      count_r    <= {(PW+1){1'b0}};
      overflow_r <= 1'b0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1'b1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1'b1);
      count_r <= count_r + {{PW{1'b0}}, push_s} - {{PW{1'b0}}, pop_s};
      if (push_req_s && !push_s) overflow_r <= 1'b1;
      else if (fstat_clr_s)      overflow_r <= 1'b0;
    end
  end

  // Scratch word with per-byte enables
  always_ff @(posedge clk) begin
    if (reset) begin
      scratch_r <= 32'd0;
    end else if (wr_s && (ofs_s == OFS_SCRATCH)) begin
      scratch_r <= be_merge(scratch_r, WData, BE);
    end
  end

  // Result FSM with watchdog; a valid STATUS code beats a same-cycle expiry
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_RUN;
      wdt_r     <= 32'd0;
      done_r    <= 1'b0;
      pass_r    <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (status_wr_s && (WData == CODE_PASS)) begin
            state_r <= ST_PASSED;
            done_r  <= 1'b1;
            pass_r  <= 1'b1;
          end else if (status_wr_s && (WData == CODE_FAIL)) begin
            state_r <= ST_FAILED;
            done_r  <= 1'b1;
          end else if (status_acc_s) begin
            wdt_r <= 32'd0;
          end else if (WDT_EN && (wdt_r == WDT_LAST)) begin
            state_r   <= ST_TIMEOUT;
            done_r    <= 1'b1;
            timeout_r <= 1'b1;
          end else begin
            wdt_r <= wdt_r + 32'd1;
          end
        end
        default: state_r <= state_r;
      endcase
    end
  end

  assign RData        = rdata_r;
  assign char_valid   = valid_s;
  assign char_data    = valid_s ? mem_r[rd_ptr_r] : 8'h00;
  assign test_done    = done_r;
  assign test_pass    = pass_r;
  assign test_timeout = timeout_r;

endmodule

// File: tb/tb_tbman_regs.sv
// Directed bench for tbman_regs: a vector table for single-cycle register accesses plus
// hand-written sequences for counter, FIFO, result FSM and watchdog timing.
module tb_tbman_regs;

  logic        clk = 1'b0;
  logic        reset;
  logic        CS_TBMAN_N;
  logic        WE;
  logic [3:0]  BE;
  logic [11:0] Addr;
  logic [31:0] WData;
  logic [31:0] RData;
  logic [7:0]  char_data;
  logic        char_valid;
  logic        char_ready;
  logic        test_done;
  logic        test_pass;
  logic        test_timeout;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tbman_regs #(.FIFO_DEPTH(16), .WDT_CYCLES(50)) dut (
    .clk(clk), .reset(reset), .CS_TBMAN_N(CS_TBMAN_N), .WE(WE), .BE(BE),
    .Addr(Addr), .WData(WData), .RData(RData), .char_data(char_data),
    .char_valid(char_valid), .char_ready(char_ready), .test_done(test_done),
    .test_pass(test_pass), .test_timeout(test_timeout)
  );

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [19];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the access edge.
  task automatic access(input logic we_i, input logic [3:0] be_i,
                        input logic [11:0] a, input logic [31:0] d);
    CS_TBMAN_N = 1'b0; WE = we_i; BE = be_i; Addr = a; WData = d;
    @(negedge clk);
    CS_TBMAN_N = 1'b1; WE = 1'b0; BE = 4'h0; Addr = 12'h000; WData = 32'h0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; CS_TBMAN_N = 1'b1; WE = 1'b0; char_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: actual running required finished");
    $fatal(1);
  end

  initial begin
    logic [7:0] drain_exp;
    reset = 1'b1; CS_TBMAN_N = 1'b1; WE = 1'b0; BE = 4'h0; Addr = 12'h000;
    WData = 32'h0; char_ready = 1'b0;

    vecs[0]  = '{1'b1, 4'b0101, 12'h014, 32'hDEADBEEF, 32'h0000_0000};
    vecs[1]  = '{1'b0, 4'b0000, 12'h014, 32'h0,        32'h00AD_00EF};
    vecs[2]  = '{1'b1, 4'b1010, 12'h014, 32'h12345678, 32'h00AD_00EF};
    vecs[3]  = '{1'b0, 4'b0000, 12'h014, 32'h0,        32'h12AD_56EF};
    vecs[4]  = '{1'b0, 4'b0000, 12'h000, 32'h0,        32'h0000_0000};
    vecs[5]  = '{1'b1, 4'b0000, 12'h014, 32'hFFFFFFFF, 32'h0000_0000};
    vecs[6]  = '{1'b0, 4'b0000, 12'h014, 32'h0,        32'h12AD_56EF};
    vecs[7]  = '{1'b0, 4'b0000, 12'h018, 32'h0,        32'h0000_0000};
    vecs[8]  = '{1'b1, 4'b1111, 12'h018, 32'hFFFFFFFF, 32'h0000_0000};
    vecs[9]  = '{1'b0, 4'b0000, 12'hFFC, 32'h0,        32'h0000_0000};
    vecs[10] = '{1'b1, 4'b0001, 12'h000, 32'h00000041, 32'h0000_0000};
    vecs[11] = '{1'b1, 4'b1110, 12'h000, 32'h00000042, 32'h0000_0000};
    vecs[12] = '{1'b0, 4'b0000, 12'h010, 32'h0,        32'h0000_0001};
    vecs[13] = '{1'b0, 4'b0000, 12'h017, 32'h0,        32'h12AD_56EF};
    vecs[14] = '{1'b1, 4'b0111, 12'h004, 32'h0000600D, 32'h12AD_56EF};
    vecs[15] = '{1'b0, 4'b0000, 12'h004, 32'h0,        32'h0000_0000};
    vecs[16] = '{1'b1, 4'b1111, 12'h004, 32'h00001234, 32'h0000_0000};
    vecs[17] = '{1'b0, 4'b0000, 12'h004, 32'h0,        32'h0000_0000};
    vecs[18] = '{1'b0, 4'b0000, 12'h00C, 32'h0,        32'h0000_0000};

    @(negedge clk);

    // Reset state and cycle counter
    do_reset();
    chk("reset_rdata", RData, 0);
    chk("reset_char_valid", char_valid, 0);
    chk("reset_char_data", char_data, 0);
    chk("reset_done_pass_timeout", {test_done, test_pass, test_timeout}, 0);
    idle(11);
    access(1'b0, 4'h0, 12'h008, 32'h0);
    chk("cyc_lo_after_11", RData, 11);
    access(1'b0, 4'h0, 12'h00C, 32'h0);
    chk("cyc_hi_snap", RData, 0);
    access(1'b0, 4'h0, 12'h008, 32'h0);
    chk("cyc_lo_after_13", RData, 13);

    // Register vector table
    do_reset();
    for (int i = 0; i < 19; i++) begin
      access(vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata);
      chk($sformatf("vec%0d_rdata", i), RData, vecs[i].exp_rdata);
    end
    chk("vec_fifo_valid", char_valid, 1);
    chk("vec_fifo_head", char_data, 8'h41);

    // Console 'H','i' with a ready sink
    do_reset();
    char_ready = 1'b1;
    access(1'b1, 4'b0001, 12'h000, 32'h48);
    chk("hi_first_valid", char_valid, 1);
    chk("hi_first_data", char_data, 8'h48);
    access(1'b1, 4'b0001, 12'h000, 32'h69);
    chk("hi_second_valid", char_valid, 1);
    chk("hi_second_data", char_data, 8'h69);
    idle(1);
    chk("hi_drained_valid", char_valid, 0);
    char_ready = 1'b0;

    // FIFO overflow, clear, push+pop while full, drain order
    do_reset();
    for (int i = 0; i < 17; i++) access(1'b1, 4'b0001, 12'h000, 32'(8'h10 + i));
    access(1'b0, 4'h0, 12'h010, 32'h0);
    chk("fstat_overflow", RData, 32'h8000_8010);
    access(1'b1, 4'b1000, 12'h010, 32'h0);
    access(1'b0, 4'h0, 12'h010, 32'h0);
    chk("fstat_cleared", RData, 32'h0000_8010);
    char_ready = 1'b1;
    access(1'b1, 4'b0001, 12'h000, 32'hAA);
    char_ready = 1'b0;
    access(1'b0, 4'h0, 12'h010, 32'h0);
    chk("fstat_full_pushpop", RData, 32'h0000_8010);
    char_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      drain_exp = (k == 15) ? 8'hAA : 8'(8'h11 + k);
      chk($sformatf("drain%0d_data", k), char_data, drain_exp);
      chk($sformatf("drain%0d_valid", k), char_valid, 1);
      @(negedge clk);
    end
    chk("drain_empty", char_valid, 0);
    char_ready = 1'b0;

    // PASS then FAIL code: first event wins, terminal state ignores watchdog
    do_reset();
    access(1'b1, 4'hF, 12'h004, 32'h0000_600D);
    chk("pass_flags", {test_done, test_pass, test_timeout}, 3'b110);
    access(1'b1, 4'hF, 12'h004, 32'h0000_0BAD);
    chk("pass_retained", {test_done, test_pass, test_timeout}, 3'b110);
    access(1'b0, 4'h0, 12'h004, 32'h0);
    chk("pass_status_read", RData, 32'h3);
    idle(60);
    chk("pass_no_timeout", {test_done, test_pass, test_timeout}, 3'b110);

    // FAIL code
    do_reset();
    access(1'b1, 4'hF, 12'h004, 32'h0000_0BAD);
    chk("fail_flags", {test_done, test_pass, test_timeout}, 3'b100);
    access(1'b1, 4'hF, 12'h004, 32'h0000_600D);
    access(1'b0, 4'h0, 12'h004, 32'h0);
    chk("fail_status_read", RData, 32'h1);

    // Watchdog expiry at cycle 50
    do_reset();
    idle(49);
    chk("wdt_before_expiry", test_done, 0);
    idle(1);
    chk("wdt_expired", {test_done, test_pass, test_timeout}, 3'b101);
    access(1'b1, 4'hF, 12'h004, 32'h0000_600D);
    access(1'b0, 4'h0, 12'h004, 32'h0);
    chk("wdt_status_read", RData, 32'h5);

    // STATUS write on the expiry cycle wins
    do_reset();
    idle(49);
    access(1'b1, 4'hF, 12'h004, 32'h0000_600D);
    chk("wdt_race_pass", {test_done, test_pass, test_timeout}, 3'b110);

    // STATUS read restarts the watchdog
    do_reset();
    idle(30);
    access(1'b0, 4'h0, 12'h004, 32'h0);
    chk("wdt_kick_read", RData, 0);
    idle(49);
    chk("wdt_kick_not_expired", test_done, 0);
    idle(1);
    chk("wdt_kick_expired", {test_done, test_pass, test_timeout}, 3'b101);

    // Reset in the middle of FIFO traffic and after a read
    do_reset();
    access(1'b1, 4'hF, 12'h014, 32'h5A5A_5A5A);
    access(1'b1, 4'b0001, 12'h000, 32'h33);
    access(1'b1, 4'b0001, 12'h000, 32'h44);
    access(1'b0, 4'h0, 12'h014, 32'h0);
    chk("mid_scratch_read", RData, 32'h5A5A_5A5A);
    chk("mid_fifo_valid", char_valid, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_reset_rdata", RData, 0);
    chk("mid_reset_valid", char_valid, 0);
    access(1'b0, 4'h0, 12'h010, 32'h0);
    chk("mid_reset_fstat", RData, 0);
    access(1'b0, 4'h0, 12'h014, 32'h0);
    chk("mid_reset_scratch", RData, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
